mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BURST_MAX, default 4, max consecutive accesses per grant when the other requester waits (1..15).
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports cpu_req / dma_req  input  1  access request, held until the access is performed.
REQ-005 SHALL have ports cpu_we / dma_we  input  1  1 = write, 0 = read.
REQ-006 SHALL have ports cpu_addr / dma_addr  input  4  word address.
REQ-007 SHALL have ports cpu_wdata / dma_wdata  input  8  write data.
REQ-008 SHALL have ports cpu_gnt / dma_gnt  output  1  registered grant; requester owns memory while high.
REQ-009 SHALL have ports cpu_ack / dma_ack  output  1  one-cycle pulse the cycle after an access is performed.
REQ-010 SHALL have port rdata  output  8  registered read data, valid while the matching ack is high.
REQ-011 SHALL have ports mem_address  output  4, mem_data_in  output  8, mem_read  output  1, mem_write  output  1  to memory_module.
REQ-012 SHALL have port mem_data_out  input  8  combinational read data from memory_module.

Function
REQ-013 SHALL implement FSM states IDLE, OWN_CPU, OWN_DMA; gnt outputs decoded from state (cpu_gnt = OWN_CPU, dma_gnt = OWN_DMA).
REQ-014 IDLE: only cpu_req -> OWN_CPU; only dma_req -> OWN_DMA; both -> requester not equal to last_owner; neither -> stay.
REQ-015 Grant latency SHALL be exactly one cycle from request sample in IDLE to gnt high.
REQ-016 An access SHALL be performed in every cycle where owner's gnt and req are both high; mem_read = ~we, mem_write = we, address/data muxed from owner.
REQ-017 In IDLE, or when owner's req is low, mem_read and mem_write SHALL be 0; mem_address and mem_data_in SHALL be 0.
REQ-018 On an access, next cycle owner's ack SHALL be 1 and rdata SHALL hold mem_data_out sampled at the access (reads) or be unchanged (writes).
REQ-019 Owner state with own req low: other req high -> other's OWN state; else -> IDLE; last_owner updated to departing owner.
REQ-020 Burst counter (4 bits) SHALL increment per access, clear on every ownership change; saturates at 15.
REQ-021 Ownership SHALL never transfer in a cycle where the owner performs an access unless the burst limit (REQ-027) applies; that access still completes and acks.
REQ-022 At most one of cpu_gnt, dma_gnt SHALL be high in any cycle; mem_read and mem_write SHALL never be high together.
REQ-023 Requester losing grant with req still high SHALL keep waiting; it is re-granted via REQ-019 rules with no loss of its pending request.

Reset
REQ-024 reset SHALL force state IDLE, last_owner = DMA (CPU wins first tie), burst count 0, cpu_ack = dma_ack = 0, rdata = 0x00.
REQ-025 reset asserted mid-access SHALL take priority: no ack issued for that access; memory write in that cycle is still driven combinationally.

Configuration
REQ-026 Macro MEM_ARB_BURST_LIMIT_EN SHALL compile the burst limit in or out.
REQ-027 With MEM_ARB_BURST_LIMIT_EN: after the access bringing count to BURST_MAX, if other req high, ownership SHALL pass to the other requester next cycle.
REQ-028 Without MEM_ARB_BURST_LIMIT_EN: owner keeps grant while its req stays high, regardless of count; BURST_MAX unused.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, OWN_CPU, OWN_DMA), owner enum (OWNER_CPU, OWNER_DMA), ADDR_W = 4, DATA_W = 8.
REQ-030 No sub-module; single module with FSM, burst counter, output mux and rdata/ack registers.

Verification
REQ-031 Reset, then cpu_req=1 read addr 0x3 (mem holds 0xA5) -> cpu_gnt high cycle 1, mem_read cycle 1, cpu_ack=1 and rdata=0xA5 cycle 2.
REQ-032 cpu_req and dma_req raised together from IDLE after reset -> CPU granted first; after CPU drops req, DMA granted next cycle.
REQ-033 DMA writes 0x5C to addr 0xF -> mem_write=1, mem_address=0xF, mem_data_in=0x5C one cycle; dma_ack pulse next cycle; CPU read of 0xF returns 0x5C.
REQ-034 MEM_ARB_BURST_LIMIT_EN, BURST_MAX=4, CPU holds req, DMA requests -> exactly 4 CPU acks, then dma_gnt; without macro CPU keeps grant indefinitely.
REQ-035 reset asserted during granted DMA access -> next cycle IDLE, no ack, both gnt 0, rdata 0x00.
REQ-036 Random req/we traffic 1000 cycles -> never both gnt, never read+write together, every access acked exactly once.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the CPU/DMA memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_DMA = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, grant/ack and memory-side signals of the arbiter.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              cpu_gnt;
  logic              dma_gnt;
  logic              cpu_ack;
  logic              dma_ack;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_data_out,
    output cpu_gnt, dma_gnt, cpu_ack, dma_ack, rdata,
    output mem_address, mem_data_in, mem_read, mem_write
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_data_out,
    input  cpu_gnt, dma_gnt, cpu_ack, dma_ack, rdata,
    input  mem_address, mem_data_in, mem_read, mem_write
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (CPU/DMA) single-port memory arbiter with registered grants.
// Define MEM_ARB_BURST_LIMIT_EN to force hand-over after BURST_MAX accesses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

`ifdef MEM_ARB_BURST_LIMIT_EN
  localparam bit BURST_LIMIT_EN = 1'b1;
`else
  localparam bit BURST_LIMIT_EN = 1'b0;
`endif

  localparam logic [3:0] BURST_LIMIT =
    (BURST_MAX < 1)  ? 4'd1  :
    (BURST_MAX > 15) ? 4'd15 : 4'(BURST_MAX);

  state_t            state, state_nxt;
  owner_t            last_owner, last_owner_nxt;
  logic [3:0]        burst_cnt, burst_inc;
  logic              burst_hit;
  logic              cpu_acc, dma_acc, access;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  assign cpu_acc = (state == OWN_CPU) && bus.cpu_req;
  assign dma_acc = (state == OWN_DMA) && bus.dma_req;
  assign access  = cpu_acc || dma_acc;

  always_comb begin
    acc_we    = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    if (cpu_acc) begin
      acc_we    = bus.cpu_we;
      acc_addr  = bus.cpu_addr;
      acc_wdata = bus.cpu_wdata;
    end else if (dma_acc) begin
      acc_we    = bus.dma_we;
      acc_addr  = bus.dma_addr;
      acc_wdata = bus.dma_wdata;
    end
  end

  assign bus.mem_read    = access && !acc_we;
  assign bus.mem_write   = access && acc_we;
  assign bus.mem_address = acc_addr;
  assign bus.mem_data_in = acc_wdata;
  assign bus.cpu_gnt     = (state == OWN_CPU);
  assign bus.dma_gnt     = (state == OWN_DMA);

  // Hit is judged on the post-access count so the limiting access itself completes.
  assign burst_inc = (burst_cnt == 4'hF) ? burst_cnt : burst_cnt + 4'd1;
  assign burst_hit = BURST_LIMIT_EN && (burst_inc == BURST_LIMIT);

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    case (state)
      IDLE: begin
        if (bus.cpu_req && bus.dma_req)
          state_nxt = (last_owner == OWNER_DMA) ? OWN_CPU : OWN_DMA;
        else if (bus.cpu_req)
          state_nxt = OWN_CPU;
        else if (bus.dma_req)
          state_nxt = OWN_DMA;
      end
      OWN_CPU: begin
        if (!bus.cpu_req || (burst_hit && bus.dma_req)) begin
          last_owner_nxt = OWNER_CPU;
          state_nxt      = bus.dma_req ? OWN_DMA : IDLE;
        end
      end
      OWN_DMA: begin
        if (!bus.dma_req || (burst_hit && bus.cpu_req)) begin
          last_owner_nxt = OWNER_DMA;
          state_nxt      = bus.cpu_req ? OWN_CPU : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      last_owner  <= OWNER_DMA;
      burst_cnt   <= '0;
      bus.cpu_ack <= 1'b0;
      bus.dma_ack <= 1'b0;
      bus.rdata   <= '0;
    end else begin
      state       <= state_nxt;
      last_owner  <= last_owner_nxt;
      if (state_nxt != state)
        burst_cnt <= '0;
      else if (access)
        burst_cnt <= burst_inc;
      bus.cpu_ack <= cpu_acc;
      bus.dma_ack <= dma_acc;
      if (access && !acc_we)
        bus.rdata <= bus.mem_data_out;
    end
  end

endmodule
